zap_ptw_fsm: RTL and testbench

Hardware page-table walker that services TLB misses for the MMU. When the TLB check stage asserts `o_walk`, this block walks the ARMv4/v5 two-level translation table in memory over a single-master Wishbone port. On success it writes one refill entry into the section, large, small or fine-page TLB RAM; on failure it returns a translation-fault FSR/FAR. It sits between the TLB check stage and the cache/memory arbiter. The requester then replays its lookup.

---
 rtl/zap_ptw_fsm_pkg.sv | 57 +++++
 rtl/zap_ptw_fsm_desc_decode.sv | 78 +++++++
 rtl/zap_ptw_fsm.sv | 207 ++++++++++++++++++++
 tb/tb_zap_ptw_fsm.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zap_ptw_fsm_pkg.sv
// Shared types, descriptor encodings and TLB entry field positions for the
// ARMv4/v5 two-level page-table walker.
package zap_ptw_fsm_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_L1,
        S_DECODE_L1,
        S_FETCH_L2,
        S_DECODE_L2,
        S_REFILL,
        S_FAULT
    } ptw_state_t;

    typedef enum logic [2:0] {
        ENT_NONE,
        ENT_SECTION,
        ENT_LARGE,
        ENT_SMALL,
        ENT_FINE
    } ptw_entry_t;

    localparam logic [3:0] FSR_SECTION_XLATE = 4'h5;
    localparam logic [3:0] FSR_PAGE_XLATE    = 4'h7;

    localparam logic [1:0] L1_FAULT   = 2'b00;
    localparam logic [1:0] L1_COARSE  = 2'b01;
    localparam logic [1:0] L1_SECTION = 2'b10;
    localparam logic [1:0] L1_FINE    = 2'b11;

    localparam logic [1:0] L2_FAULT = 2'b00;
    localparam logic [1:0] L2_LARGE = 2'b01;
    localparam logic [1:0] L2_SMALL = 2'b10;
    localparam logic [1:0] L2_TINY  = 2'b11;

    // DAC_SEL[3:0], CB[1:0] and the low end of AP sit at the same place in every entry.
    localparam int ZAP_TLB__DAC_SEL_LO = 0;
    localparam int ZAP_TLB__CB_LO      = 4;
    localparam int ZAP_TLB__AP_LO      = 6;

    localparam int ZAP_SECTION_TLB__BASE_LO = 8;
    localparam int ZAP_SECTION_TLB__TAG_LO  = 20;
    localparam int ZAP_SECTION_TLB_WDT      = 32;

    localparam int ZAP_LPAGE_TLB__BASE_LO = 14;
    localparam int ZAP_LPAGE_TLB__TAG_LO  = 30;
    localparam int ZAP_LPAGE_TLB_WDT      = 46;

    localparam int ZAP_SPAGE_TLB__BASE_LO = 14;
    localparam int ZAP_SPAGE_TLB__TAG_LO  = 34;
    localparam int ZAP_SPAGE_TLB_WDT      = 54;

    localparam int ZAP_FPAGE_TLB__BASE_LO = 8;
    localparam int ZAP_FPAGE_TLB__TAG_LO  = 30;
    localparam int ZAP_FPAGE_TLB_WDT      = 52;

endpackage

// File: rtl/zap_ptw_fsm_desc_decode.sv
// Combinational descriptor-type decode, L2 address formation and TLB entry
// packing for section, large, small and fine page entries.
module zap_ptw_desc_decode
    import zap_ptw_fsm_pkg::*;
#(
    parameter int LPAGE_TLB_ENTRIES   = 8,
    parameter int SPAGE_TLB_ENTRIES   = 8,
    parameter int SECTION_TLB_ENTRIES = 8,
    parameter int FPAGE_TLB_ENTRIES   = 8
) (
    input  logic [31:0]                    va,
    input  logic [31:0]                    l1,
    input  logic [31:0]                    l2,
    input  logic [3:0]                     domain,
    input  logic                           fine_tbl,
    output logic [1:0]                     l1_type,
    output logic [31:0]                    l2_adr,
    output ptw_entry_t                     l2_entry,
    output logic [ZAP_SECTION_TLB_WDT-1:0] se_wdata,
    output logic [ZAP_LPAGE_TLB_WDT-1:0]   lp_wdata,
    output logic [ZAP_SPAGE_TLB_WDT-1:0]   sp_wdata,
    output logic [ZAP_FPAGE_TLB_WDT-1:0]   fp_wdata
);

    // Tags drop the VA bits each RAM already uses as its index.
    localparam int SE_IDX_W = $clog2(SECTION_TLB_ENTRIES);
    localparam int LP_IDX_W = $clog2(LPAGE_TLB_ENTRIES);
    localparam int SP_IDX_W = $clog2(SPAGE_TLB_ENTRIES);
    localparam int FP_IDX_W = $clog2(FPAGE_TLB_ENTRIES);

    logic unused_bits;
    assign unused_bits = ^{l1[9], l1[4], va[9:0]};

    assign l1_type = l1[1:0];
    assign l2_adr  = (l1[1:0] == L1_FINE) ? {l1[31:12], va[19:10], 2'b00}
                                          : {l1[31:10], va[19:12], 2'b00};

    always_comb begin
        l2_entry = ENT_NONE;
        case (l2[1:0])
            L2_LARGE: l2_entry = ENT_LARGE;
            L2_SMALL: l2_entry = ENT_SMALL;
            L2_TINY:  l2_entry = fine_tbl ? ENT_FINE : ENT_NONE;
            default:  l2_entry = ENT_NONE;
        endcase
    end

    always_comb begin
        se_wdata = '0;
        se_wdata[ZAP_TLB__DAC_SEL_LO +: 4]       = l1[8:5];
        se_wdata[ZAP_TLB__CB_LO +: 2]            = l1[3:2];
        se_wdata[ZAP_TLB__AP_LO +: 2]            = l1[11:10];
        se_wdata[ZAP_SECTION_TLB__BASE_LO +: 12] = l1[31:20];
        se_wdata[ZAP_SECTION_TLB__TAG_LO +: 12]  = 12'(va[31:20] >> SE_IDX_W);

        lp_wdata = '0;
        lp_wdata[ZAP_TLB__DAC_SEL_LO +: 4]     = domain;
        lp_wdata[ZAP_TLB__CB_LO +: 2]          = l2[3:2];
        lp_wdata[ZAP_TLB__AP_LO +: 8]          = l2[11:4];
        lp_wdata[ZAP_LPAGE_TLB__BASE_LO +: 16] = l2[31:16];
        lp_wdata[ZAP_LPAGE_TLB__TAG_LO +: 16]  = 16'(va[31:16] >> LP_IDX_W);

        sp_wdata = '0;
        sp_wdata[ZAP_TLB__DAC_SEL_LO +: 4]     = domain;
        sp_wdata[ZAP_TLB__CB_LO +: 2]          = l2[3:2];
        sp_wdata[ZAP_TLB__AP_LO +: 8]          = l2[11:4];
        sp_wdata[ZAP_SPAGE_TLB__BASE_LO +: 20] = l2[31:12];
        sp_wdata[ZAP_SPAGE_TLB__TAG_LO +: 20]  = 20'(va[31:12] >> SP_IDX_W);

        fp_wdata = '0;
        fp_wdata[ZAP_TLB__DAC_SEL_LO +: 4]     = domain;
        fp_wdata[ZAP_TLB__CB_LO +: 2]          = l2[3:2];
        fp_wdata[ZAP_TLB__AP_LO +: 2]          = l2[5:4];
        fp_wdata[ZAP_FPAGE_TLB__BASE_LO +: 22] = l2[31:10];
        fp_wdata[ZAP_FPAGE_TLB__TAG_LO +: 22]  = 22'(va[31:10] >> FP_IDX_W);
    end

endmodule

// File: rtl/zap_ptw_fsm.sv
// Page-table walker: services a TLB miss by reading L1/L2 descriptors over
// Wishbone and either writing one TLB entry or returning a translation fault.
module zap_ptw_fsm
    import zap_ptw_fsm_pkg::*;
#(
    parameter int LPAGE_TLB_ENTRIES   = 8,
    parameter int SPAGE_TLB_ENTRIES   = 8,
    parameter int SECTION_TLB_ENTRIES = 8,
    parameter int FPAGE_TLB_ENTRIES   = 8
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_walk,
    input  logic [31:0]                    i_va,
    input  logic [17:0]                    i_baddr,
    output logic                           o_busy,
    output logic                           o_done,
    output logic [7:0]                     o_fsr,
    output logic [31:0]                    o_far,
    output logic                           o_wb_cyc,
    output logic                           o_wb_stb,
    output logic [31:0]                    o_wb_adr,
    input  logic                           i_wb_ack,
    input  logic [31:0]                    i_wb_dat,
    output logic                           o_setlb_wen,
    output logic                           o_lptlb_wen,
    output logic                           o_sptlb_wen,
    output logic                           o_fptlb_wen,
    output logic [31:0]                    o_tlb_wva,
    output logic [ZAP_SECTION_TLB_WDT-1:0] o_setlb_wdata,
    output logic [ZAP_LPAGE_TLB_WDT-1:0]   o_lptlb_wdata,
    output logic [ZAP_SPAGE_TLB_WDT-1:0]   o_sptlb_wdata,
    output logic [ZAP_FPAGE_TLB_WDT-1:0]   o_fptlb_wdata,
    output ptw_state_t                     o_dbg_state
);

    // Bus: cyc/stb and adr are held constant from the first FETCH cycle until
    // the cycle i_wb_ack is seen high; cyc/stb drop on the following cycle.
    ptw_state_t state;
    logic [31:0] va_q;
    logic [31:0] l1_q;
    logic [31:0] l2_q;
    logic [3:0]  domain_q;
    logic        fine_q;

    logic [1:0]                     l1_type;
    logic [31:0]                    l2_adr;
    ptw_entry_t                     l2_entry;
    logic [ZAP_SECTION_TLB_WDT-1:0] se_wdata;
    logic [ZAP_LPAGE_TLB_WDT-1:0]   lp_wdata;
    logic [ZAP_SPAGE_TLB_WDT-1:0]   sp_wdata;
    logic [ZAP_FPAGE_TLB_WDT-1:0]   fp_wdata;

    assign o_dbg_state = state;

    zap_ptw_desc_decode #(
        .LPAGE_TLB_ENTRIES   (LPAGE_TLB_ENTRIES),
        .SPAGE_TLB_ENTRIES   (SPAGE_TLB_ENTRIES),
        .SECTION_TLB_ENTRIES (SECTION_TLB_ENTRIES),
        .FPAGE_TLB_ENTRIES   (FPAGE_TLB_ENTRIES)
    ) u_decode (
        .va       (va_q),
        .l1       (l1_q),
        .l2       (l2_q),
        .domain   (domain_q),
        .fine_tbl (fine_q),
        .l1_type  (l1_type),
        .l2_adr   (l2_adr),
        .l2_entry (l2_entry),
        .se_wdata (se_wdata),
        .lp_wdata (lp_wdata),
        .sp_wdata (sp_wdata),
        .fp_wdata (fp_wdata)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= S_IDLE;
            va_q          <= '0;
            l1_q          <= '0;
            l2_q          <= '0;
            domain_q      <= '0;
            fine_q        <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_fsr         <= '0;
            o_far         <= '0;
            o_wb_cyc      <= 1'b0;
            o_wb_stb      <= 1'b0;
            o_wb_adr      <= '0;
            o_setlb_wen   <= 1'b0;
            o_lptlb_wen   <= 1'b0;
            o_sptlb_wen   <= 1'b0;
            o_fptlb_wen   <= 1'b0;
            o_tlb_wva     <= '0;
            o_setlb_wdata <= '0;
            o_lptlb_wdata <= '0;
            o_sptlb_wdata <= '0;
            o_fptlb_wdata <= '0;
        end else begin
            o_done      <= 1'b0;
            o_setlb_wen <= 1'b0;
            o_lptlb_wen <= 1'b0;
            o_sptlb_wen <= 1'b0;
            o_fptlb_wen <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (i_walk) begin
                        va_q     <= i_va;
                        o_wb_adr <= {i_baddr, i_va[31:20], 2'b00};
                        o_wb_cyc <= 1'b1;
                        o_wb_stb <= 1'b1;
                        o_busy   <= 1'b1;
                        state    <= S_FETCH_L1;
                    end
                end

                S_FETCH_L1: begin
                    if (i_wb_ack) begin
                        l1_q     <= i_wb_dat;
                        o_wb_cyc <= 1'b0;
                        o_wb_stb <= 1'b0;
                        state    <= S_DECODE_L1;
                    end
                end

                S_DECODE_L1: begin
                    domain_q <= l1_q[8:5];
                    fine_q   <= (l1_type == L1_FINE);
                    case (l1_type)
                        L1_FAULT: begin
                            o_done <= 1'b1;
                            o_fsr  <= {4'd0, FSR_SECTION_XLATE};
                            o_far  <= va_q;
                            state  <= S_FAULT;
                        end
                        L1_SECTION: begin
                            o_setlb_wdata <= se_wdata;
                            o_setlb_wen   <= 1'b1;
                            o_tlb_wva     <= va_q;
                            o_done        <= 1'b1;
                            o_fsr         <= '0;
                            o_far         <= va_q;
                            state         <= S_REFILL;
                        end
                        default: begin
                            o_wb_adr <= l2_adr;
                            o_wb_cyc <= 1'b1;
                            o_wb_stb <= 1'b1;
                            state    <= S_FETCH_L2;
                        end
                    endcase
                end

                S_FETCH_L2: begin
                    if (i_wb_ack) begin
                        l2_q     <= i_wb_dat;
                        o_wb_cyc <= 1'b0;
                        o_wb_stb <= 1'b0;
                        state    <= S_DECODE_L2;
                    end
                end

                S_DECODE_L2: begin
                    o_far <= va_q;
                    o_done <= 1'b1;
                    if (l2_entry == ENT_NONE) begin
                        o_fsr <= {domain_q, FSR_PAGE_XLATE};
                        state <= S_FAULT;
                    end else begin
                        o_fsr     <= '0;
                        o_tlb_wva <= va_q;
                        state     <= S_REFILL;
                        case (l2_entry)
                            ENT_LARGE: begin
                                o_lptlb_wdata <= lp_wdata;
                                o_lptlb_wen   <= 1'b1;
                            end
                            ENT_SMALL: begin
                                o_sptlb_wdata <= sp_wdata;
                                o_sptlb_wen   <= 1'b1;
                            end
                            default: begin
                                o_fptlb_wdata <= fp_wdata;
                                o_fptlb_wen   <= 1'b1;
                            end
                        endcase
                    end
                end

                S_REFILL, S_FAULT: begin
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end

                default: begin
                    o_busy   <= 1'b0;
                    o_wb_cyc <= 1'b0;
                    o_wb_stb <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zap_ptw_fsm.sv
// Directed bench for zap_ptw_fsm: a table of walks with a Wishbone responder,
// plus hand-written reset-mid-walk and back-to-back request sequences.
module tb_zap_ptw_fsm;
    import zap_ptw_fsm_pkg::*;

    logic        clk = 1'b0;
    logic        i_reset, i_walk;
    logic [31:0] i_va;
    logic [17:0] i_baddr;
    logic        o_busy, o_done;
    logic [7:0]  o_fsr;
    logic [31:0] o_far;
    logic        o_wb_cyc, o_wb_stb;
    logic [31:0] o_wb_adr;
    logic        i_wb_ack;
    logic [31:0] i_wb_dat;
    logic        o_setlb_wen, o_lptlb_wen, o_sptlb_wen, o_fptlb_wen;
    logic [31:0] o_tlb_wva;
    logic [ZAP_SECTION_TLB_WDT-1:0] o_setlb_wdata;
    logic [ZAP_LPAGE_TLB_WDT-1:0]   o_lptlb_wdata;
    logic [ZAP_SPAGE_TLB_WDT-1:0]   o_sptlb_wdata;
    logic [ZAP_FPAGE_TLB_WDT-1:0]   o_fptlb_wdata;
    ptw_state_t  o_dbg_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    zap_ptw_fsm dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .i_walk        (i_walk),
        .i_va          (i_va),
        .i_baddr       (i_baddr),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_fsr         (o_fsr),
        .o_far         (o_far),
        .o_wb_cyc      (o_wb_cyc),
        .o_wb_stb      (o_wb_stb),
        .o_wb_adr      (o_wb_adr),
        .i_wb_ack      (i_wb_ack),
        .i_wb_dat      (i_wb_dat),
        .o_setlb_wen   (o_setlb_wen),
        .o_lptlb_wen   (o_lptlb_wen),
        .o_sptlb_wen   (o_sptlb_wen),
        .o_fptlb_wen   (o_fptlb_wen),
        .o_tlb_wva     (o_tlb_wva),
        .o_setlb_wdata (o_setlb_wdata),
        .o_lptlb_wdata (o_lptlb_wdata),
        .o_sptlb_wdata (o_sptlb_wdata),
        .o_fptlb_wdata (o_fptlb_wdata),
        .o_dbg_state   (o_dbg_state)
    );

    typedef struct {
        string       name;
        logic [17:0] baddr;
        logic [31:0] va;
        logic [31:0] l1;
        logic [31:0] l2;
        int          waits;
        int          fetches;
        logic [31:0] l1_adr;
        logic [31:0] l2_adr;
        int          done_cyc;
        logic [3:0]  wen;     // {section, large, small, fine}
        logic [7:0]  fsr;
        logic [31:0] base;
        logic [7:0]  ap;
        logic [1:0]  cb;
        logic [3:0]  dac;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic [17:0] b, input logic [31:0] va,
                                input logic [31:0] l1, input logic [31:0] l2, input int w,
                                input int nf, input logic [31:0] a1, input logic [31:0] a2,
                                input int dc, input logic [3:0] wen, input logic [7:0] fsr,
                                input logic [31:0] base, input logic [7:0] ap,
                                input logic [1:0] cb, input logic [3:0] dac);
        vec_t v;
        v.name = n; v.baddr = b; v.va = va; v.l1 = l1; v.l2 = l2; v.waits = w;
        v.fetches = nf; v.l1_adr = a1; v.l2_adr = a2; v.done_cyc = dc; v.wen = wen;
        v.fsr = fsr; v.base = base; v.ap = ap; v.cb = cb; v.dac = dac;
        return v;
    endfunction

    task automatic run_walk(input vec_t v);
        logic [31:0] adr[2];
        logic [31:0] cur_adr = '0;
        logic        prev_stb = 1'b0;
        int          nfetch = 0;
        int          wait_n = 0;
        int          done_cyc = -1;
        int          wen_cnt = 0;
        int          unstable = 0;
        logic [3:0]  wen_s = '0;
        logic [7:0]  fsr_s = '0;
        logic [31:0] far_s = '0;
        logic [31:0] wva_s = '0;
        logic [31:0] base = '0;
        logic [7:0]  ap = '0;
        logic [1:0]  cb = '0;
        logic [3:0]  dac = '0;
        adr[0] = '0;
        adr[1] = '0;

        @(negedge clk);
        i_baddr = v.baddr;
        i_va    = v.va;
        i_walk  = 1'b1;
        @(posedge clk);
        #1;
        i_walk  = 1'b0;
        i_baddr = 18'h2AAAA;
        i_va    = 32'hDEAD_BEEF;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            if (o_wb_stb) begin
                if (!prev_stb) begin
                    if (nfetch < 2) adr[nfetch] = o_wb_adr;
                    cur_adr = o_wb_adr;
                    nfetch++;
                    wait_n = 0;
                end else if (o_wb_adr !== cur_adr) begin
                    unstable++;
                end
                if (wait_n == v.waits) begin
                    i_wb_ack = 1'b1;
                    i_wb_dat = (nfetch == 1) ? v.l1 : v.l2;
                end
                wait_n++;
            end
            prev_stb = o_wb_stb;
            if ({o_setlb_wen, o_lptlb_wen, o_sptlb_wen, o_fptlb_wen} != 4'b0) wen_cnt++;
            if (o_done) begin
                done_cyc = cyc;
                wen_s = {o_setlb_wen, o_lptlb_wen, o_sptlb_wen, o_fptlb_wen};
                fsr_s = o_fsr;
                far_s = o_far;
                wva_s = o_tlb_wva;
                case (wen_s)
                    4'b1000: begin
                        base = 32'(o_setlb_wdata[ZAP_SECTION_TLB__BASE_LO +: 12]);
                        ap   = 8'(o_setlb_wdata[ZAP_TLB__AP_LO +: 2]);
                        cb   = o_setlb_wdata[ZAP_TLB__CB_LO +: 2];
                        dac  = o_setlb_wdata[ZAP_TLB__DAC_SEL_LO +: 4];
                    end
                    4'b0100: begin
                        base = 32'(o_lptlb_wdata[ZAP_LPAGE_TLB__BASE_LO +: 16]);
                        ap   = o_lptlb_wdata[ZAP_TLB__AP_LO +: 8];
                        cb   = o_lptlb_wdata[ZAP_TLB__CB_LO +: 2];
                        dac  = o_lptlb_wdata[ZAP_TLB__DAC_SEL_LO +: 4];
                    end
                    4'b0010: begin
                        base = 32'(o_sptlb_wdata[ZAP_SPAGE_TLB__BASE_LO +: 20]);
                        ap   = o_sptlb_wdata[ZAP_TLB__AP_LO +: 8];
                        cb   = o_sptlb_wdata[ZAP_TLB__CB_LO +: 2];
                        dac  = o_sptlb_wdata[ZAP_TLB__DAC_SEL_LO +: 4];
                    end
                    4'b0001: begin
                        base = 32'(o_fptlb_wdata[ZAP_FPAGE_TLB__BASE_LO +: 22]);
                        ap   = 8'(o_fptlb_wdata[ZAP_TLB__AP_LO +: 2]);
                        cb   = o_fptlb_wdata[ZAP_TLB__CB_LO +: 2];
                        dac  = o_fptlb_wdata[ZAP_TLB__DAC_SEL_LO +: 4];
                    end
                    default: ;
                endcase
                break;
            end
            @(posedge clk);
            #1;
            i_wb_ack = 1'b0;
        end
        @(posedge clk);
        #1;
        i_wb_ack = 1'b0;

        check({v.name, " fetches"}, 64'(nfetch), 64'(v.fetches));
        check({v.name, " l1_adr"}, 64'(adr[0]), 64'(v.l1_adr));
        if (v.fetches == 2) check({v.name, " l2_adr"}, 64'(adr[1]), 64'(v.l2_adr));
        check({v.name, " adr_stable"}, 64'(unstable), 64'd0);
        check({v.name, " done_cycle"}, 64'(done_cyc), 64'(v.done_cyc));
        check({v.name, " wen"}, 64'(wen_s), 64'(v.wen));
        check({v.name, " wen_cycles"}, 64'(wen_cnt), (v.wen != 4'b0) ? 64'd1 : 64'd0);
        check({v.name, " fsr"}, 64'(fsr_s), 64'(v.fsr));
        check({v.name, " far"}, 64'(far_s), 64'(v.va));
        if (v.wen != 4'b0) begin
            check({v.name, " wva"}, 64'(wva_s), 64'(v.va));
            check({v.name, " base"}, 64'(base), 64'(v.base));
            check({v.name, " ap"}, 64'(ap), 64'(v.ap));
            check({v.name, " cb"}, 64'(cb), 64'(v.cb));
            check({v.name, " dac_sel"}, 64'(dac), 64'(v.dac));
        end

        @(negedge clk);
        check({v.name, " idle_after"},
              64'({o_busy, o_done, o_wb_stb, o_setlb_wen, o_lptlb_wen, o_sptlb_wen, o_fptlb_wen}),
              64'd0);
    endtask

    initial begin
        //            name        baddr     va            l1            l2            w  nf l1_adr        l2_adr        done wen      fsr    base       ap     cb     dac
        vecs[0]  = mk("section",  18'h00001, 32'h1230_0456, 32'h8000_0C1E, 32'h0,        0, 1, 32'h0000_448C, 32'h0,        3, 4'b1000, 8'h00, 32'h800,   8'h03, 2'b11, 4'h0);
        vecs[1]  = mk("small",    18'h00001, 32'h1230_0456, 32'h0010_0021, 32'h0ABC_DFFE, 0, 2, 32'h0000_448C, 32'h0010_0000, 5, 4'b0010, 8'h00, 32'h0ABCD, 8'hFF, 2'b11, 4'h1);
        vecs[2]  = mk("l1_fault", 18'h00001, 32'h1230_0456, 32'h0,        32'h0,        0, 1, 32'h0000_448C, 32'h0,        3, 4'b0000, 8'h05, 32'h0,     8'h00, 2'b00, 4'h0);
        vecs[3]  = mk("l2_fault", 18'h00001, 32'h1230_0456, 32'h0010_0021, 32'h0,        0, 2, 32'h0000_448C, 32'h0010_0000, 5, 4'b0000, 8'h17, 32'h0,     8'h00, 2'b00, 4'h0);
        vecs[4]  = mk("tiny_crs", 18'h00001, 32'h1230_0456, 32'h0010_0021, 32'h0ABC_DFFF, 0, 2, 32'h0000_448C, 32'h0010_0000, 5, 4'b0000, 8'h17, 32'h0,     8'h00, 2'b00, 4'h0);
        vecs[5]  = mk("large",    18'h00001, 32'h1230_0456, 32'h0010_0021, 32'hABCD_0045, 0, 2, 32'h0000_448C, 32'h0010_0000, 5, 4'b0100, 8'h00, 32'hABCD,  8'h04, 2'b01, 4'h1);
        vecs[6]  = mk("fine",     18'h00001, 32'h1230_0456, 32'h0020_0023, 32'h1234_5673, 0, 2, 32'h0000_448C, 32'h0020_0004, 5, 4'b0001, 8'h00, 32'h48D15, 8'h03, 2'b00, 4'h1);
        vecs[7]  = mk("sec_wait", 18'h00001, 32'h1230_0456, 32'h8000_0C1E, 32'h0,        3, 1, 32'h0000_448C, 32'h0,        6, 4'b1000, 8'h00, 32'h800,   8'h03, 2'b11, 4'h0);
        vecs[8]  = mk("sp_wait",  18'h00001, 32'h1230_0456, 32'h0010_0021, 32'h0ABC_DFFE, 3, 2, 32'h0000_448C, 32'h0010_0000, 11, 4'b0010, 8'h00, 32'h0ABCD, 8'hFF, 2'b11, 4'h1);
        vecs[9]  = mk("adr_top",  18'h3FFFF, 32'hFFF0_0000, 32'h0,        32'h0,        0, 1, 32'hFFFF_FFFC, 32'h0,        3, 4'b0000, 8'h05, 32'h0,     8'h00, 2'b00, 4'h0);
        vecs[10] = mk("sec_domF", 18'h00000, 32'h0000_0000, 32'hFFF0_01E6, 32'h0,        0, 1, 32'h0000_0000, 32'h0,        3, 4'b1000, 8'h00, 32'hFFF,   8'h00, 2'b01, 4'hF);

        i_reset  = 1'b1;
        i_walk   = 1'b0;
        i_va     = '0;
        i_baddr  = '0;
        i_wb_ack = 1'b0;
        i_wb_dat = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", 64'(o_dbg_state), 64'(S_IDLE));
        check("reset_ctl", 64'({o_busy, o_done, o_wb_cyc, o_wb_stb, o_setlb_wen, o_lptlb_wen, o_sptlb_wen, o_fptlb_wen}), 64'd0);
        check("reset_fsr_far", 64'({o_fsr, o_far}), 64'd0);
        check("reset_adr_wva", 64'({o_wb_adr, o_tlb_wva}), 64'd0);
        check("reset_wdata", 64'(o_setlb_wdata) | 64'(o_lptlb_wdata) | 64'(o_sptlb_wdata) | 64'(o_fptlb_wdata), 64'd0);
        i_reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_walk(vecs[i]);
            if (i == 0) check("section tag", 64'(o_setlb_wdata[ZAP_SECTION_TLB__TAG_LO +: 12]), 64'h024);
        end

        // Reset asserted while the L2 fetch is outstanding; its ack lands in IDLE.
        begin
            int fetch_n = 0;
            logic prev = 1'b0;
            logic hit_l2 = 1'b0;
            int stray = 0;
            @(negedge clk);
            i_baddr = 18'h00001;
            i_va    = 32'h1230_0456;
            i_walk  = 1'b1;
            @(posedge clk);
            #1;
            i_walk = 1'b0;
            for (int cyc = 1; cyc <= 20 && !hit_l2; cyc++) begin
                @(negedge clk);
                if (o_wb_stb && !prev) fetch_n++;
                prev = o_wb_stb;
                if (o_wb_stb && fetch_n == 1) begin
                    i_wb_ack = 1'b1;
                    i_wb_dat = 32'h0010_0021;
                end else if (o_wb_stb && fetch_n == 2) begin
                    i_reset = 1'b1;
                    hit_l2  = 1'b1;
                end
                @(posedge clk);
                #1;
                i_wb_ack = 1'b0;
            end
            check("rst reached FETCH_L2", 64'(hit_l2), 64'd1);
            i_reset  = 1'b0;
            i_wb_ack = 1'b1;
            i_wb_dat = 32'h0ABC_DFFE;
            @(negedge clk);
            check("rst cyc_stb_busy", 64'({o_wb_cyc, o_wb_stb, o_busy}), 64'd0);
            check("rst done_wen", 64'({o_done, o_setlb_wen, o_lptlb_wen, o_sptlb_wen, o_fptlb_wen}), 64'd0);
            check("rst state", 64'(o_dbg_state), 64'(S_IDLE));
            @(posedge clk);
            #1;
            i_wb_ack = 1'b0;
            for (int cyc = 0; cyc < 5; cyc++) begin
                @(negedge clk);
                if (o_busy || o_done || o_wb_stb || o_setlb_wen || o_lptlb_wen || o_sptlb_wen || o_fptlb_wen) stray++;
            end
            check("rst ack ignored", 64'(stray), 64'd0);
        end

        // i_walk held high: the second walk takes the VA present the cycle after o_done.
        begin
            int stb_cyc[$];
            logic [31:0] stb_adr[$];
            int done_c[$];
            logic [31:0] done_wva[$];
            logic prev = 1'b0;
            @(negedge clk);
            i_baddr = 18'h00001;
            i_va    = 32'h1230_0456;
            i_walk  = 1'b1;
            @(posedge clk);
            #1;
            for (int cyc = 1; cyc <= 20; cyc++) begin
                @(negedge clk);
                if (cyc == 2) i_va = 32'h7770_0000;
                if (o_wb_stb && !prev) begin
                    stb_cyc.push_back(cyc);
                    stb_adr.push_back(o_wb_adr);
                end
                prev = o_wb_stb;
                if (o_wb_stb) begin
                    i_wb_ack = 1'b1;
                    i_wb_dat = 32'h8000_0C1E;
                end
                if (o_done) begin
                    done_c.push_back(cyc);
                    done_wva.push_back(o_tlb_wva);
                    if (done_c.size() == 1) i_va = 32'h4560_0000;
                    else i_walk = 1'b0;
                end
                @(posedge clk);
                #1;
                i_wb_ack = 1'b0;
            end
            i_walk = 1'b0;
            check("b2b walks", 64'(stb_cyc.size()), 64'd2);
            check("b2b dones", 64'(done_c.size()), 64'd2);
            if (done_c.size() == 2 && stb_cyc.size() == 2) begin
                check("b2b done1 cycle", 64'(done_c[0]), 64'd3);
                check("b2b wva1", 64'(done_wva[0]), 64'h1230_0456);
                check("b2b walk2 start", 64'(stb_cyc[1]), 64'd5);
                check("b2b walk2 adr", 64'(stb_adr[1]), 64'h0000_5158);
                check("b2b done2 cycle", 64'(done_c[1]), 64'd7);
                check("b2b wva2", 64'(done_wva[1]), 64'h4560_0000);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
